// File: rtl/bcd_display_scan_if.sv
// Display bus between the BCD counter chain and the multiplexed 7-segment scanner.
// master = counter/set-mode side, slave = scan driver.
interface bcd_display_scan_if #(
    parameter int N_DIGITS = 6
);
    logic [4*N_DIGITS-1:0]       bcd_in;
    logic [N_DIGITS-1:0]         blink_mask;
    logic [N_DIGITS-1:0]         dp_mask;
    logic [6:0]                  seg;
    logic                        dp;
    logic [N_DIGITS-1:0]         an;
    logic [$clog2(N_DIGITS)-1:0] digit_idx;
    logic                        frame_start;

    modport master (
        output bcd_in, blink_mask, dp_mask,
        input  seg, dp, an, digit_idx, frame_start
    );

    modport slave (
        input  bcd_in, blink_mask, dp_mask,
        output seg, dp, an, digit_idx, frame_start
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed active-low 7-segment scanner with per-frame BCD snapshot and blink.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero in the most significant digit.
module bcd_display_scan #(
    parameter int N_DIGITS  = 6,
    parameter int SCAN_DIV  = 1000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    bcd_display_scan_if.slave bus
);
    localparam int DW = $clog2(N_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]           digit_idx_q, digit_idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*N_DIGITS-1:0]   snap_q, snap_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;

    logic                    frame_edge;
    logic [3:0]              nib;
    logic                    blink_sel;
    logic                    dp_sel;
    logic [N_DIGITS-1:0]     an_sel;
    logic [6:0]              glyph;

    always_comb begin
        frame_edge = (scan_cnt_q == SCAN_LAST) && (digit_idx_q == DIGIT_LAST);

        scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + DW'(1);
        end

        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

        // Snapshot only at the frame boundary so one frame never mixes two bcd_in values
        snap_d = frame_edge ? bus.bcd_in : snap_q;

        nib       = '0;
        blink_sel = 1'b0;
        dp_sel    = 1'b0;
        an_sel    = '1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (digit_idx_q == DW'(k)) begin
                nib       = snap_q[4*k +: 4];
                blink_sel = bus.blink_mask[k];
                dp_sel    = bus.dp_mask[k];
                an_sel[k] = 1'b0;
            end
        end

        case (nib)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            default: glyph = 7'h3F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_idx_q == DIGIT_LAST) && (nib == 4'd0)) begin
            glyph = 7'h7F;
        end
`endif

        if (scan_cnt_q < GUARD_END) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
            an_d  = '1;
        end else begin
            // Blanking touches seg/dp only; an keeps sequencing so brightness is unchanged
            an_d = an_sel;
            if (blink_phase_q && blink_sel) begin
                seg_d = 7'h7F;
                dp_d  = 1'b1;
            end else begin
                seg_d = glyph;
                dp_d  = ~dp_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= '0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.digit_idx   = digit_idx_q;
    assign bus.frame_start = frame_edge;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized self-checking bench for bcd_display_scan against a cycle-count based reference model.
module tb_bcd_display_scan;
    localparam int N  = 6;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BD = 64;
    localparam int FR = N * SD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_display_scan_if #(.N_DIGITS(N)) bus ();

    bcd_display_scan #(
        .N_DIGITS (N),
        .SCAN_DIV (SD),
        .GUARD    (GD),
        .BLINK_DIV(BD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: s = clock edges since the last reset edge; the scan state
    // during cycle s is scan=s%SD, digit=(s/SD)%N, blink phase=(s/BD)%2.
    logic [6:0]   seg_tab [16];
    int           s      = 0;
    logic         mvalid = 1'b0;
    logic [4*N-1:0] msnap;
    logic [6:0]   e_seg;
    logic         e_dp;
    logic [N-1:0] e_an;
    int           e_didx;
    logic         e_fs;

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h3F;
    end

    always @(posedge clk) begin
        int sc, dg, ph, nb;
        if (rst) begin
            s      = 0;
            msnap  = '0;
            e_seg  = 7'h7F;
            e_dp   = 1'b1;
            e_an   = '1;
            mvalid = 1'b1;
        end else begin
            sc = s % SD;
            dg = (s / SD) % N;
            ph = (s / BD) % 2;
            nb = int'((msnap >> (4 * dg)) & 24'hF);
            if (sc < GD) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = '1;
            end else begin
                e_an = ~(N'(1) << dg);
                if (ph == 1 && bus.blink_mask[dg]) begin
                    e_seg = 7'h7F; e_dp = 1'b1;
                end else begin
                    e_seg = seg_tab[nb];
`ifdef LEADING_ZERO_BLANK_EN
                    if (dg == N - 1 && nb == 0) e_seg = 7'h7F;
`endif
                    e_dp = ~bus.dp_mask[dg];
                end
            end
            if (sc == SD - 1 && dg == N - 1) msnap = bus.bcd_in;
            s++;
        end
        e_didx = (s / SD) % N;
        e_fs   = (s % SD == SD - 1) && (e_didx == N - 1);
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("seg", int'(bus.seg), int'(e_seg));
            chk("dp", int'(bus.dp), int'(e_dp));
            chk("an", int'(bus.an), int'(e_an));
            chk("digit_idx", int'(bus.digit_idx), e_didx);
            chk("frame_start", int'(bus.frame_start), int'(e_fs));
            chk("an_onehot", int'($countones(~bus.an) <= 1), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until cycle s sits at frame position ph (and blink phase bp of the displayed state, if bp>=0)
    task automatic goto(input int ph, input int bp);
        int n;
        n = 0;
        step();
        while (!((s % FR) == ph && (bp < 0 || (((s - 1) / BD) % 2) == bp)) && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) chk("goto_timeout", 1, 0);
    endtask

    function automatic logic [4*N-1:0] rand_bcd();
        logic [4*N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    initial begin
        logic [6:0] slot_exp [N];
        int first_fs;
        int an0_low;
        slot_exp[0] = 7'h10; slot_exp[1] = 7'h12; slot_exp[2] = 7'h10;
        slot_exp[3] = 7'h12; slot_exp[4] = 7'h30; slot_exp[5] = 7'h24;
        bus.bcd_in     = '0;
        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", int'(bus.seg), 'h7F);
        chk("rst_an", int'(bus.an), 'h3F);
        chk("rst_dp", int'(bus.dp), 1);
        rst        = 1'b0;
        bus.bcd_in = 24'h235959;

        first_fs = -1;
        an0_low  = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (bus.frame_start && first_fs < 0) first_fs = i;
            if (i == 2) chk("pre_frame_seg", int'(bus.seg), 'h40);
            if (i >= 24 && i <= 32 && !bus.an[0]) an0_low++;
            for (int k = 0; k < N; k++)
                if (i == 24 + 4 * k + 2 && k < 2) chk("frame2_slot", int'(bus.seg), int'(slot_exp[k]));
            if (i == 33) bus.bcd_in = 24'h000000;
            if (i == 42) chk("no_tear_slot4", int'(bus.seg), 'h30);
            if (i == 46) chk("no_tear_slot5", int'(bus.seg), 'h24);
            if (i == 50) chk("new_frame_slot0", int'(bus.seg), 'h40);
        end
        chk("first_frame_start", first_fs, 23);
        chk("an0_low_cycles", an0_low, 3);

        bus.bcd_in     = 24'h235959;
        bus.blink_mask = 6'b110000;
        bus.dp_mask    = 6'b010100;
        repeat (30) step();
        goto(18, 1);
        chk("blink_slot4_seg", int'(bus.seg), 'h7F);
        chk("blink_slot4_dp", int'(bus.dp), 1);
        goto(18, 0);
        chk("vis_slot4_seg", int'(bus.seg), 'h30);
        chk("vis_slot4_dp", int'(bus.dp), 0);
        goto(10, -1);
        chk("slot2_seg", int'(bus.seg), 'h10);
        chk("slot2_dp", int'(bus.dp), 0);
        goto(22, 0);
        chk("vis_slot5_seg", int'(bus.seg), 'h24);

        bus.blink_mask = '0;
        bus.dp_mask    = '0;
        bus.bcd_in     = 24'h00A000;
        repeat (30) step();
        goto(14, -1);
        chk("dash_slot3", int'(bus.seg), 'h3F);

        bus.bcd_in = 24'h095959;
        repeat (30) step();
        goto(22, -1);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lzb_zero", int'(bus.seg), 'h7F);
`else
        chk("lead_zero", int'(bus.seg), 'h40);
`endif
        bus.bcd_in = 24'h105959;
        repeat (30) step();
        goto(22, -1);
        chk("lead_one", int'(bus.seg), 'h79);

        goto(13, -1);
        rst = 1'b1;
        step();
        chk("midrst_an", int'(bus.an), 'h3F);
        chk("midrst_didx", int'(bus.digit_idx), 0);
        chk("midrst_seg", int'(bus.seg), 'h7F);
        rst = 1'b0;

        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 15) == 0) bus.bcd_in = rand_bcd();
            if ($urandom_range(0, 31) == 0) bus.blink_mask = N'($urandom);
            if ($urandom_range(0, 31) == 0) bus.dp_mask = N'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
